// File: rtl/mood_counter_sched_pkg.sv
// Shared state and operation encodings for the mood counter scheduler.
package mood_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_RUN   = 2'd0;
   localparam state_t S_DECAY = 2'd1;
   localparam state_t S_CLEAR = 2'd2;

   localparam logic OP_INC = 1'b0;
   localparam logic OP_DEC = 1'b1;

endpackage

// File: rtl/mood_counter_sched_rr_arbiter.sv
// Round-robin arbiter: first eligible requester at or after ptr, scanning circularly.
module rr_arbiter
   import mood_pkg::*;
#(
   parameter int unsigned  NREQ = 4,
   localparam int unsigned PTRW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] mask,
   input  logic [PTRW-1:0] ptr,
   output logic [NREQ-1:0] winner,
   output logic            valid
);

   logic [NREQ-1:0] elig;
   logic [PTRW-1:0] idx;

   assign elig = req & ~mask;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         idx = PTRW'((32'(ptr) + off) % NREQ);
         if (!valid && elig[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mood_counter_sched.sv
// Round-robin scheduler driving a bank of saturating counters (inc/dec/setval).
// The periodic decay sweep is built only when MOOD_SCHED_DECAY_EN is defined.
module mood_counter_sched
   import mood_pkg::*;
#(
   parameter int unsigned  NREQ         = 4,
   parameter int unsigned  NCNT         = 4,
   parameter int unsigned  DECAY_PERIOD = 16,
   localparam int unsigned SELW         = $clog2(NCNT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_op,
   input  logic [NREQ*SELW-1:0] req_sel,
   input  logic                 clr,
   output logic [NREQ-1:0]      gnt,
   output logic [NCNT-1:0]      cnt_inc,
   output logic [NCNT-1:0]      cnt_dec,
   output logic [NCNT-1:0]      cnt_setval,
   output logic                 decay_busy
);

   localparam int unsigned PTRW = $clog2(NREQ);

   state_t          state_q, state_d;
   logic [PTRW-1:0] ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NCNT-1:0] inc_q, inc_d;
   logic [NCNT-1:0] dec_q, dec_d;
   logic [NCNT-1:0] setval_q, setval_d;

   logic [NREQ-1:0] win;
   logic            win_vld;
   logic [PTRW-1:0] win_idx;
   logic [SELW-1:0] win_sel;
   logic            win_op;
   logic            run_ok;

`ifdef MOOD_SCHED_DECAY_EN
   localparam int unsigned TW = $clog2(DECAY_PERIOD);

   logic [TW-1:0]   timer_q, timer_d;
   logic [SELW-1:0] sweep_q, sweep_d;
   logic            busy_q, busy_d;
`else
   logic unused_decay_period;
   assign unused_decay_period = (DECAY_PERIOD != 0);
`endif

   // Masking with the current grant stops a still-held request from winning twice.
   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req    (req),
      .mask   (gnt_q),
      .ptr    (ptr_q),
      .winner (win),
      .valid  (win_vld)
   );

   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win[i]) win_idx = PTRW'(i);
      end
   end

   assign win_sel = req_sel[win_idx*SELW +: SELW];
   assign win_op  = req_op[win_idx];

   always_comb begin
      state_d  = S_RUN;
      ptr_d    = ptr_q;
      gnt_d    = '0;
      inc_d    = '0;
      dec_d    = '0;
      setval_d = '0;
      run_ok   = 1'b0;
`ifdef MOOD_SCHED_DECAY_EN
      timer_d  = timer_q;
      sweep_d  = sweep_q;
      busy_d   = 1'b0;
`endif
      if (clr) begin
         state_d  = S_CLEAR;
         setval_d = '1;
`ifdef MOOD_SCHED_DECAY_EN
         timer_d  = '0;
         sweep_d  = '0;
`endif
      end else begin
         case (state_q)
`ifdef MOOD_SCHED_DECAY_EN
            S_DECAY: begin
               timer_d = '0;
               // sweep_q is the bit currently on cnt_dec; the last sweep cycle emits nothing
               if (sweep_q == SELW'(NCNT - 1)) begin
                  sweep_d = '0;
               end else begin
                  state_d          = S_DECAY;
                  sweep_d          = sweep_q + 1'b1;
                  dec_d[sweep_d]   = 1'b1;
                  busy_d           = 1'b1;
               end
            end
`endif
            default: begin
               run_ok = 1'b1;
`ifdef MOOD_SCHED_DECAY_EN
               if (timer_q == TW'(DECAY_PERIOD - 1)) begin
                  run_ok   = 1'b0;
                  state_d  = S_DECAY;
                  timer_d  = '0;
                  sweep_d  = '0;
                  dec_d[0] = 1'b1;
                  busy_d   = 1'b1;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
`endif
            end
         endcase
      end

      if (run_ok && win_vld) begin
         gnt_d = win;
         ptr_d = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
         if (32'(win_sel) < NCNT) begin
            if (win_op == OP_INC) inc_d[win_sel] = 1'b1;
            else                  dec_d[win_sel] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_RUN;
         ptr_q    <= '0;
         gnt_q    <= '0;
         inc_q    <= '0;
         dec_q    <= '0;
         setval_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         inc_q    <= inc_d;
         dec_q    <= dec_d;
         setval_q <= setval_d;
      end
   end

`ifdef MOOD_SCHED_DECAY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_q <= '0;
         sweep_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         timer_q <= timer_d;
         sweep_q <= sweep_d;
         busy_q  <= busy_d;
      end
   end

   assign decay_busy = busy_q;
`else
   assign decay_busy = 1'b0;
`endif

   assign gnt        = gnt_q;
   assign cnt_inc    = inc_q;
   assign cnt_dec    = dec_q;
   assign cnt_setval = setval_q;

endmodule
